// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: shared types, widths and LFSR step function for the MMIO bus controller.
package mmio_bus_pkg;
  localparam int DATA_W = 32;
  localparam int NIB_W = 4;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction
endpackage

// File: rtl/mmio_lfsr32.sv
// mmio_lfsr32: 32-bit Galois LFSR with seed load, step enable and a guard that never lets the state reach 0.
module mmio_lfsr32
  import mmio_bus_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);
  localparam logic [31:0] RST_VAL = (SEED == 32'h0) ? 32'h1 : SEED;
  logic [31:0] state_q, state_d, nxt;
  always_comb begin
    nxt = load ? seed : step ? lfsr_next(state_q) : state_q;
    state_d = (nxt == 32'h0) ? 32'h1 : nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RST_VAL;
    else state_q <= state_d;
  end
  assign state = state_q;
endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU-to-slave MMIO controller with nibble decode, req/ack handshake, timeout and LFSR source.
// Optional MMIO_ERR_CAPTURE_EN adds error address/count capture and an err_cnt clear via the random source.
module mmio_bus_ctrl
  import mmio_bus_pkg::*;
#(
  parameter int                    NUM_SLV   = 4,
  parameter logic [4*NUM_SLV-1:0]  BASE_MAP  = {4'hF, 4'hE, 4'hD, 4'h0},
  parameter logic [3:0]            RAND_NIB  = 4'hC,
  parameter int                    TIMEOUT   = 15,
  parameter logic [31:0]           LFSR_SEED = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_req,
  input  logic                      mem_w,
  input  logic [31:0]               addr_bus,
  input  logic [31:0]               Cpu_data2bus,
  output logic [31:0]               Cpu_data4bus,
  output logic                      bus_ready,
  output logic                      bus_err,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic                      slv_we,
  output logic [27:0]               slv_addr,
  output logic [31:0]               slv_wdata,
  input  logic [32*NUM_SLV-1:0]     slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  output logic [31:0]               err_addr,
  output logic [7:0]                err_cnt
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef MMIO_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [27:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata, lfsr;
  logic [NUM_SLV-1:0] sel_q, sel_d, hit_oh;
  logic we_q, we_d, err_q, err_d, ack_hit, is_rand, lfsr_load, lfsr_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Descending scan so the lowest matching channel is the last one written.
  always_comb begin
    hit_oh = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if (BASE_MAP[NIB_W*i +: NIB_W] == addr_bus[31:28]) begin
        hit_oh = '0;
        hit_oh[i] = 1'b1;
      end
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (sel_q[i]) sel_rdata = slv_rdata[DATA_W*i +: DATA_W];
  end
  assign ack_hit = |(slv_ack & sel_q);
  assign is_rand = addr_bus[31:28] == RAND_NIB;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d = sel_q;
    we_d = we_q;
    err_d = err_q;
    cnt_d = cnt_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: if (mem_req) begin
        addr_d = addr_bus[27:0];
        wdata_d = Cpu_data2bus;
        err_d = 1'b0;
        state_d = (|hit_oh) ? ACCESS : RESP;
        if (|hit_oh) begin
          sel_d = hit_oh;
          we_d = mem_w;
          cnt_d = '0;
        end else if (is_rand) begin
          rdata_d = mem_w ? rdata_q : lfsr;
          lfsr_step = !mem_w;
          lfsr_load = mem_w && !(ERR_EN && addr_bus[2]);
        end else begin
          err_d = 1'b1;
          rdata_d = mem_w ? rdata_q : '0;
        end
      end
      ACCESS: begin
        cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        if (ack_hit || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          sel_d = '0;
          we_d = 1'b0;
          err_d = !ack_hit;
          rdata_d = we_q ? rdata_q : ack_hit ? sel_rdata : '0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q <= sel_d;
      we_q <= we_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  mmio_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (Cpu_data2bus),
    .step (lfsr_step),
    .state(lfsr)
  );
  assign Cpu_data4bus = rdata_q;
  assign bus_ready = state_q == RESP;
  assign bus_err = (state_q == RESP) && err_q;
  assign slv_sel = sel_q;
  assign slv_we = we_q;
  assign slv_addr = addr_q;
  assign slv_wdata = wdata_q;
`ifdef MMIO_ERR_CAPTURE_EN
  logic [3:0] nib_q, nib_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic err_clr, err_resp;
  assign err_clr = state_q == IDLE && mem_req && !(|hit_oh) && is_rand && mem_w && addr_bus[2];
  assign err_resp = state_q == RESP && err_q;
  always_comb begin
    nib_d = (state_q == IDLE && mem_req) ? addr_bus[31:28] : nib_q;
    err_addr_d = err_resp ? {nib_q, addr_q} : err_addr_q;
    err_cnt_d = err_clr ? 8'h00 : (err_resp && !(&err_cnt_q)) ? err_cnt_q + 8'h01 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nib_q <= '0;
      err_addr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      nib_q <= nib_d;
      err_addr_q <= err_addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign err_addr = err_addr_q;
  assign err_cnt = err_cnt_q;
`else
  assign err_addr = '0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed checks of decode, latency, timeout, LFSR sequence, reseed and async reset.
module tb_mmio_bus_ctrl;
  logic clk, rst, mem_req, mem_w, bus_ready, bus_err, slv_we;
  logic [31:0] addr_bus, Cpu_data2bus, Cpu_data4bus, slv_wdata, err_addr;
  logic [3:0] slv_sel, slv_ack;
  logic [27:0] slv_addr;
  logic [127:0] slv_rdata;
  logic [7:0] err_cnt;
  int vectors = 0;
  int miscompares = 0;

  mmio_bus_ctrl dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_w(mem_w), .addr_bus(addr_bus),
    .Cpu_data2bus(Cpu_data2bus), .Cpu_data4bus(Cpu_data4bus), .bus_ready(bus_ready),
    .bus_err(bus_err), .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_req = 1'b1;
    mem_w = w;
    addr_bus = a;
    Cpu_data2bus = d;
  endtask

  task automatic wait_rdy(input string tag, input int start, input int exp_cyc, input logic exp_err);
    int cyc = start;
    while (!bus_ready && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, exp_err});
  endtask

  task automatic idle();
    mem_req = 1'b0;
    mem_w = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    mem_req = 1'b0;
    mem_w = 1'b0;
    addr_bus = '0;
    Cpu_data2bus = '0;
    slv_ack = '0;
    slv_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    tick();
    tick();
    check("rst_ready", {31'b0, bus_ready}, 32'h0);
    check("rst_sel", {28'b0, slv_sel}, 32'h0);
    check("rst_data", Cpu_data4bus, 32'h0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    rst = 1'b1;
    tick();
    // LFSR sequence from the default seed
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("rnd0", 1, 2, 1'b0);
    check("rnd0_data", Cpu_data4bus, 32'h0000_0001);
    idle();
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("rnd1", 1, 2, 1'b0);
    check("rnd1_data", Cpu_data4bus, 32'h8020_0003);
    idle();
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("rnd2", 1, 2, 1'b0);
    check("rnd2_data", Cpu_data4bus, 32'hC030_0002);
    idle();
    // zero-wait read on channel 0
    slv_ack = 4'b0001;
    req(1'b0, 32'h0000_0010, 32'h0);
    tick();
    check("ch0_sel", {28'b0, slv_sel}, 32'h1);
    check("ch0_addr", {4'b0, slv_addr}, 32'h10);
    check("ch0_we", {31'b0, slv_we}, 32'h0);
    wait_rdy("ch0", 2, 3, 1'b0);
    check("ch0_data", Cpu_data4bus, 32'hDEAD_BEEF);
    check("ch0_sel_drop", {28'b0, slv_sel}, 32'h0);
    slv_ack = 4'b0000;
    idle();
    // write to channel 2 with four wait cycles; stray ack on ch1 must be ignored
    slv_ack = 4'b0010;
    req(1'b1, 32'hE000_0000, 32'h0000_005A);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("ch2_sel", {28'b0, slv_sel}, 32'h4);
      check("ch2_we", {31'b0, slv_we}, 32'h1);
      check("ch2_wdata", slv_wdata, 32'h5A);
      check("ch2_ready", {31'b0, bus_ready}, 32'h0);
      if (k == 6) slv_ack = 4'b0100;
    end
    wait_rdy("ch2", 6, 7, 1'b0);
    check("ch2_data_held", Cpu_data4bus, 32'hDEAD_BEEF);
    slv_ack = 4'b0000;
    idle();
    // timeout on channel 3
    req(1'b0, 32'hF000_0004, 32'h0);
    tick();
    check("to_sel", {28'b0, slv_sel}, 32'h8);
    wait_rdy("to", 2, 17, 1'b1);
    check("to_sel_drop", {28'b0, slv_sel}, 32'h0);
    check("to_data", Cpu_data4bus, 32'h0);
    idle();
`ifdef MMIO_ERR_CAPTURE_EN
    check("to_err_cnt", {24'b0, err_cnt}, 32'h1);
    check("to_err_addr", err_addr, 32'hF000_0004);
`else
    check("to_err_cnt", {24'b0, err_cnt}, 32'h0);
    check("to_err_addr", err_addr, 32'h0);
`endif
    // unmapped read after a nonzero data value
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("rnd3", 1, 2, 1'b0);
    idle();
    req(1'b0, 32'h7000_0000, 32'h0);
    check("unm_sel_c1", {28'b0, slv_sel}, 32'h0);
    wait_rdy("unm", 1, 2, 1'b1);
    check("unm_sel", {28'b0, slv_sel}, 32'h0);
    check("unm_data", Cpu_data4bus, 32'h0);
    idle();
`ifdef MMIO_ERR_CAPTURE_EN
    check("unm_err_cnt", {24'b0, err_cnt}, 32'h2);
    check("unm_err_addr", err_addr, 32'h7000_0000);
`endif
    // reseed, then a write with addr[2]=1 (clear under capture, reseed to 1 otherwise)
    req(1'b1, 32'hC000_0000, 32'h1234_5678);
    wait_rdy("seed_w", 1, 2, 1'b0);
    idle();
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("seed_r", 1, 2, 1'b0);
    check("seed_data", Cpu_data4bus, 32'h1234_5678);
    idle();
    req(1'b1, 32'hC000_0004, 32'h0);
    wait_rdy("clr_w", 1, 2, 1'b0);
    check("clr_data_held", Cpu_data4bus, 32'h1234_5678);
    idle();
    check("clr_err_cnt", {24'b0, err_cnt}, 32'h0);
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("clr_r", 1, 2, 1'b0);
`ifdef MMIO_ERR_CAPTURE_EN
    check("clr_r_data", Cpu_data4bus, 32'h091A_2B3C);
`else
    check("clr_r_data", Cpu_data4bus, 32'h0000_0001);
`endif
    idle();
    // async reset in the middle of an access
    req(1'b0, 32'h0000_0000, 32'h0);
    tick();
    check("rst_acc_sel", {28'b0, slv_sel}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rst_acc_sel0", {28'b0, slv_sel}, 32'h0);
    check("rst_acc_ready", {31'b0, bus_ready}, 32'h0);
    mem_req = 1'b0;
    #1 rst = 1'b1;
    tick();
    req(1'b0, 32'hC000_0000, 32'h0);
    wait_rdy("post_rst", 1, 2, 1'b0);
    check("post_rst_data", Cpu_data4bus, 32'h0000_0001);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
